// File: rtl/motion_pkg.sv
// -----------------------------------------------------------------------------
// motion_pkg
// Shared types and constants for the motion command sequencer: axis count,
// field widths, the queued command record and the sequencer state encoding.
// -----------------------------------------------------------------------------
package motion_pkg;

    localparam int NUM_MOTORS  = 6;
    localparam int PULSE_W     = 10;
    localparam int MOTOR_IDX_W = 3;

    typedef struct packed {
        logic [MOTOR_IDX_W-1:0] motor;
        logic [PULSE_W-1:0]     pulses;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [2:0] {
        S_HOME,
        S_IDLE,
        S_ISSUE,
        S_WAIT_RISE,
        S_WAIT_FALL,
        S_PARK
    } state_t;

    // A command can be executed only if it names a real axis and moves at least one pulse.
    function automatic logic cmd_is_legal(cmd_t c);
        return (c.motor < MOTOR_IDX_W'(NUM_MOTORS)) && (c.pulses != '0);
    endfunction

    function automatic logic [NUM_MOTORS-1:0] motor_onehot(logic [MOTOR_IDX_W-1:0] idx);
        return NUM_MOTORS'(1) << idx;
    endfunction

endpackage

// File: rtl/motion_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// motion_cmd_sequencer_if
// Host command channel into the sequencer (valid/ready handshake).
//   cmd_valid  host -> seq  command valid
//   cmd_ready  seq  -> host queue can accept
//   cmd_motor  host -> seq  motor index
//   cmd_pulses host -> seq  pulse count
// master = host side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface motion_cmd_sequencer_if;
    import motion_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [MOTOR_IDX_W-1:0] cmd_motor;
    logic [PULSE_W-1:0]     cmd_pulses;

    modport master (output cmd_valid, cmd_motor, cmd_pulses, input cmd_ready);
    modport slave  (input cmd_valid, cmd_motor, cmd_pulses, output cmd_ready);
endinterface

// File: rtl/motion_cmd_sequencer_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO of move commands with flush.
//   sysclk, rst_n  clock, asynchronous active-low reset
//   flush          empty the queue (wins over push/pop)
//   push, wdata    write one entry (ignored when full)
//   pop            drop head entry (ignored when empty)
//   rdata          head entry, valid while !empty
//   empty, full    status flags
//   level          number of queued entries
// -----------------------------------------------------------------------------
module cmd_fifo
    import motion_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  cmd_t          wdata,
    input  logic          pop,
    output cmd_t          rdata,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          push_en;
    logic          pop_en;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // NOTE: storage has no reset; the pointers/level define which entries are meaningful.
    always_ff @(posedge sysclk) begin
        if (push_en && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            // Pointers are log2(DEPTH) bits wide, so they wrap naturally.
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_en, pop_en})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/motion_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// motion_cmd_sequencer
// Queues host move commands and issues them one at a time to the six-axis
// pulse generator once all origins are calibrated. Each move: drive
// motor_sel/pulse_num, wait for pulse_busy to rise then fall, then park the
// generator inputs at zero so identical back-to-back commands retrigger it.
//   sysclk, rst_n  clock, asynchronous active-low reset
//   cmd            host command channel (slave side)
//   abort          flush queue, clear err, park (level, highest priority)
//   init_flag      per-axis calibrated flags
//   pulse_busy     generator busy
//   motor_sel      one-hot axis select to generator
//   pulse_num      pulse count to generator
//   move_done      1-cycle strobe when a move's busy falls
//   err            sticky error (bad command or busy never rose)
//   fifo_level     queued entries
// -----------------------------------------------------------------------------
module motion_cmd_sequencer
    import motion_pkg::*;
#(
    parameter int  DEPTH        = 4,
    parameter int  RISE_TIMEOUT = 255,
    parameter int  PARK_CYCLES  = 2,
    localparam int LW           = $clog2(DEPTH) + 1,
    localparam int TW           = $clog2(RISE_TIMEOUT + 1),
    localparam int PW           = $clog2(PARK_CYCLES + 1)
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    motion_cmd_sequencer_if.slave   cmd,
    input  logic                    abort,
    input  logic [NUM_MOTORS-1:0]   init_flag,
    input  logic                    pulse_busy,
    output logic [NUM_MOTORS-1:0]   motor_sel,
    output logic [PULSE_W-1:0]      pulse_num,
    output logic                    move_done,
    output logic                    err,
    output logic [LW-1:0]           fifo_level
);

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [PW-1:0]         park_q, park_d;
    logic [NUM_MOTORS-1:0] motor_sel_q, motor_sel_d;
    logic [PULSE_W-1:0]    pulse_num_q, pulse_num_d;
    logic                  move_done_q, move_done_d;
    logic                  err_q, err_d;
    logic                  alive_q;

    cmd_t in_cmd, head_cmd;
    logic fifo_empty, fifo_full, accept, push, bad_cmd, pop, all_init;
    logic timer_hit, park_done;

    assign in_cmd    = '{motor: cmd.cmd_motor, pulses: cmd.cmd_pulses};
    // alive_q keeps cmd_ready low while reset is asserted and for the first edge after.
    assign cmd.cmd_ready = alive_q && !fifo_full;
    // An abort in the same cycle swallows the command.
    assign accept    = cmd.cmd_valid && cmd.cmd_ready && !abort;
    assign push      = accept && cmd_is_legal(in_cmd);
    assign bad_cmd   = accept && !cmd_is_legal(in_cmd);
    assign all_init  = &init_flag;
    assign pop       = (state_q == S_IDLE) && !abort && all_init && !fifo_empty;
    assign timer_hit = (timer_q == TW'(RISE_TIMEOUT));
    assign park_done = (park_q >= PW'(PARK_CYCLES - 1));

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .flush  (abort),
        .push   (push),
        .wdata  (in_cmd),
        .pop    (pop),
        .rdata  (head_cmd),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .level  (fifo_level)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HOME;
            timer_q     <= '0;
            park_q      <= '0;
            motor_sel_q <= '0;
            pulse_num_q <= '0;
            move_done_q <= 1'b0;
            err_q       <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            park_q      <= park_d;
            motor_sel_q <= motor_sel_d;
            pulse_num_q <= pulse_num_d;
            move_done_q <= move_done_d;
            err_q       <= err_d;
            alive_q     <= 1'b1;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise unassigned paths infer latches.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_PARK;
        end else begin
            case (state_q)
                S_HOME:      if (all_init) state_d = S_IDLE;
                S_IDLE:      if (!all_init) state_d = S_HOME;
                             else if (!fifo_empty) state_d = S_ISSUE;
                S_ISSUE:     state_d = S_WAIT_RISE;
                S_WAIT_RISE: if (pulse_busy) state_d = S_WAIT_FALL;
                             else if (timer_hit) state_d = S_PARK;
                S_WAIT_FALL: if (!pulse_busy) state_d = S_PARK;
                S_PARK:      if (!all_init) state_d = S_HOME;
                             else if (park_done && !pulse_busy) state_d = S_IDLE;
                default:     state_d = S_HOME;
            endcase
        end
    end

    always_comb begin
        motor_sel_d = motor_sel_q;
        pulse_num_d = pulse_num_q;
        move_done_d = 1'b0;
        err_d       = err_q || bad_cmd;
        timer_d     = timer_q;
        park_d      = park_q;
        if (abort) begin
            motor_sel_d = '0;
            pulse_num_d = '0;
            err_d       = 1'b0;
            park_d      = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    motor_sel_d = pop ? motor_onehot(head_cmd.motor) : '0;
                    pulse_num_d = pop ? head_cmd.pulses : '0;
                end
                S_ISSUE: timer_d = '0;
                S_WAIT_RISE: begin
                    if (!pulse_busy) begin
                        if (timer_hit) begin
                            err_d       = 1'b1;
                            motor_sel_d = '0;
                            pulse_num_d = '0;
                            park_d      = '0;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end
                S_WAIT_FALL: begin
                    if (!pulse_busy) begin
                        move_done_d = 1'b1;
                        motor_sel_d = '0;
                        pulse_num_d = '0;
                        park_d      = '0;
                    end
                end
                S_PARK: begin
                    motor_sel_d = '0;
                    pulse_num_d = '0;
                    if (!park_done) park_d = park_q + PW'(1);
                end
                default: begin
                    motor_sel_d = '0;
                    pulse_num_d = '0;
                end
            endcase
        end
    end

    assign motor_sel = motor_sel_q;
    assign pulse_num = pulse_num_q;
    assign move_done = move_done_q;
    assign err       = err_q;

endmodule
